// File: rtl/aes_inv_key_expand.sv
// AES-128 key schedule run forward to round 10, then stepped back one round key per request.
// Latency: round-10 key ready 10 cycles after kld; each accepted next yields the previous key on the same edge.
// Backpressure: none; next is honoured only when ready=1 and round>0, kld overrides everything.
//
// Ports: clk, rst_n (async, active-low); kld/key load the cipher key ({w0,w1,w2,w3});
//        next steps back one round; ready, round and rkey0..rkey3 present the current round key.

`ifdef COMPOSITE
// Computational S-box: GF(2^8) multiplicative inverse (x^254) followed by the AES affine map.
module aes_sbox_comp (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    // 254 = 8'b1111_1110: square-and-multiply over the exponent bits
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  assign y = sbox_f(a);
endmodule
`else
// Table S-box: byte n of the table lives at bits [2047-8n -: 8].
module aes_sbox_lut (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = SBOX[2047 - 8 * int'(a) -: 8];
endmodule
`endif

module aes_inv_key_expand (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kld,
  input  logic [0:127] key,
  input  logic         next,
  output logic         ready,
  output logic [3:0]   round,
  output logic [31:0]  rkey0,
  output logic [31:0]  rkey1,
  output logic [31:0]  rkey2,
  output logic [31:0]  rkey3
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, READY = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [31:0] w0, w1, w2, w3;
  logic [3:0]  rnd;
  logic        do_fwd, do_bwd, ready_c;
  logic [31:0] t, sw, rc_word;
  logic [3:0]  rc_idx;
  logic [7:0]  sb_in  [4];
  logic [7:0]  sb_out [4];
  logic [31:0] f0, f1, f2, f3;
  logic [31:0] u0, u1, u2, u3;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; kld restarts from any state
  always_comb begin
    state_nxt = state;
    if (kld) begin
      state_nxt = EXPAND;
    end else begin
      case (state)
        EXPAND:  if (rnd == 4'd9) state_nxt = READY;
        default: state_nxt = state;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    ready_c = (state == READY);
    do_fwd  = !kld && (state == EXPAND);
    do_bwd  = !kld && (state == READY) && next && (rnd != 4'd0);
  end

  // Shared S-box input: forward uses w3, backward recovers the old w3 as w3^w2.
  // Forward step r->r+1 needs rc(r+1); backward step r->r-1 needs rc(r).
  always_comb begin
    t       = (state == EXPAND) ? w3 : (w3 ^ w2);
    rc_idx  = (state == EXPAND) ? (rnd + 4'd1) : rnd;
    rc_word = {rcon(rc_idx), 24'h0};
    sb_in[0] = t[23:16];
    sb_in[1] = t[15:8];
    sb_in[2] = t[7:0];
    sb_in[3] = t[31:24];
    sw = {sb_out[0], sb_out[1], sb_out[2], sb_out[3]};
    f0 = w0 ^ sw ^ rc_word;
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    f3 = w3 ^ f2;
    u3 = w3 ^ w2;
    u2 = w2 ^ w1;
    u1 = w1 ^ w0;
    u0 = w0 ^ sw ^ rc_word;
  end

  for (genvar i = 0; i < 4; i++) begin : g_sbox
`ifdef COMPOSITE
    aes_sbox_comp u_sbox (.a(sb_in[i]), .y(sb_out[i]));
`else
    aes_sbox_lut  u_sbox (.a(sb_in[i]), .y(sb_out[i]));
`endif
  end

  // Round-key words and round counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0 <= '0; w1 <= '0; w2 <= '0; w3 <= '0;
      rnd <= 4'd0;
    end else if (kld) begin
      w0 <= key[0:31]; w1 <= key[32:63]; w2 <= key[64:95]; w3 <= key[96:127];
      rnd <= 4'd0;
    end else if (do_fwd) begin
      w0 <= f0; w1 <= f1; w2 <= f2; w3 <= f3;
      rnd <= rnd + 4'd1;
    end else if (do_bwd) begin
      w0 <= u0; w1 <= u1; w2 <= u2; w3 <= u3;
      rnd <= rnd - 4'd1;
    end
  end

  assign ready = ready_c;
  assign round = rnd;
  assign rkey0 = w0;
  assign rkey1 = w1;
  assign rkey2 = w2;
  assign rkey3 = w3;
endmodule

// File: tb/tb_aes_inv_key_expand.sv
module tb_aes_inv_key_expand;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         kld;
  logic [0:127] key;
  logic         next;
  logic         ready;
  logic [3:0]   round;
  logic [31:0]  rkey0, rkey1, rkey2, rkey3;

  int checks = 0;
  int errors = 0;

  aes_inv_key_expand dut (
    .clk(clk), .rst_n(rst_n), .kld(kld), .key(key), .next(next),
    .ready(ready), .round(round),
    .rkey0(rkey0), .rkey1(rkey1), .rkey2(rkey2), .rkey3(rkey3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] k;
    int           nnext;
    logic [127:0] exp_rk;
    logic [3:0]   exp_round;
  } vec_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  // ---------------- reference model: FIPS-197 schedule from field arithmetic ----------------
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] b;
    // brute-force multiplicative inverse (0 maps to 0)
    for (int c = 1; c < 256; c++)
      if (gf_mul(x, 8'(c)) == 8'h01) inv = 8'(c);
    b = inv;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] model_rk(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0]), m_sbox(t[31:24])} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [127:0] cur_rk();
    return {rkey0, rkey1, rkey2, rkey3};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] k);
    kld = 1'b1;
    key = k;
    tick();
    kld = 1'b0;
    chk("load_round", 128'(round), 128'd0);
    chk("load_rkey", cur_rk(), k);
  endtask

  task automatic wait_ready(input string name);
    int cnt = 0;
    while (!ready && cnt < 20) begin
      tick();
      cnt++;
    end
    chk(name, 128'(cnt), 128'd10);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{FIPS_KEY, 0,  128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd10};
    vecs[1] = '{FIPS_KEY, 1,  128'hac7766f319fadc2128d12941575c006e, 4'd9};
    vecs[2] = '{FIPS_KEY, 9,  128'ha0fafe1788542cb123a339392a6c7605, 4'd1};
    vecs[3] = '{FIPS_KEY, 10, FIPS_KEY, 4'd0};
    vecs[4] = '{FIPS_KEY, 12, FIPS_KEY, 4'd0};
    vecs[5] = '{128'h0,   0,  128'hb4ef5bcb3e92e21123e951cf6f8f188e, 4'd10};

    rst_n = 1'b0; kld = 1'b0; next = 1'b0; key = '0;
    #12;
    chk("reset_rkey", cur_rk(), 128'h0);
    chk("reset_round", 128'(round), 128'd0);
    chk("reset_ready", 128'(ready), 128'd0);
    rst_n = 1'b1;

    // idle: next must be ignored
    for (int i = 0; i < 4; i++) begin
      next = i[0];
      tick();
      chk("idle_rkey", cur_rk(), 128'h0);
      chk("idle_round_ready", {124'h0, round} | {127'h0, ready} << 4, 128'd0);
    end
    next = 1'b0;

    // table-driven known-answer vectors
    for (int v = 0; v < 6; v++) begin
      load(vecs[v].k);
      wait_ready("vec_ready_latency");
      next = 1'b1;
      for (int n = 0; n < vecs[v].nnext; n++) begin
        tick();
        chk("vec_walk_model", cur_rk(), model_rk(vecs[v].k, (10 - n - 1 < 0) ? 0 : 10 - n - 1));
      end
      next = 1'b0;
      chk("vec_rkey", cur_rk(), vecs[v].exp_rk);
      chk("vec_round", 128'(round), 128'(vecs[v].exp_round));
      chk("vec_model", cur_rk(), model_rk(vecs[v].k, int'(vecs[v].exp_round)));
      tick();
      chk("vec_hold", cur_rk(), vecs[v].exp_rk);
    end

    // kld during EXPAND restarts from the new key
    begin
      logic [127:0] k1, k2, k3;
      k1 = {$urandom, $urandom, $urandom, $urandom};
      k2 = {$urandom, $urandom, $urandom, $urandom};
      k3 = {$urandom, $urandom, $urandom, $urandom};
      load(k1);
      repeat (4) tick();
      chk("mid_expand_round", 128'(round), 128'd4);
      chk("mid_expand_rkey", cur_rk(), model_rk(k1, 4));
      load(k2);
      chk("restart_ready_low", 128'(ready), 128'd0);
      wait_ready("restart_latency");
      chk("restart_rk10", cur_rk(), model_rk(k2, 10));

      // kld and next together in READY: load wins
      next = 1'b1;
      load(k3);
      next = 1'b0;
      chk("kld_next_ready", 128'(ready), 128'd0);
      wait_ready("kld_next_latency");
      chk("kld_next_rk10", cur_rk(), model_rk(k3, 10));

      // async reset mid-stream
      next = 1'b1;
      repeat (3) tick();
      chk("pre_reset_rk7", cur_rk(), model_rk(k3, 7));
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_rkey", cur_rk(), 128'h0);
      chk("async_reset_round", 128'(round), 128'd0);
      chk("async_reset_ready", 128'(ready), 128'd0);
      next = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
    end

    // randomized keys: full expansion then walk down every round
    for (int r = 0; r < 12; r++) begin
      logic [127:0] k;
      int gap;
      k = {$urandom, $urandom, $urandom, $urandom};
      load(k);
      wait_ready("rand_latency");
      chk("rand_rk10", cur_rk(), model_rk(k, 10));
      for (int rd = 9; rd >= 0; rd--) begin
        gap = $urandom_range(0, 2);
        next = 1'b0;
        repeat (gap) tick();
        next = 1'b1;
        tick();
        chk("rand_walk", cur_rk(), model_rk(k, rd));
        chk("rand_walk_round", 128'(round), 128'(rd));
      end
      next = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
